decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
Parametrised, registered successor to the team's 5-to-32 one-hot decoder. It turns an IN_W-bit index into an OUT_W-bit select word, in one of four modes:
- one-hot
- thermometer
- active-low one-hot
- self-timed scan, where the block steps its own index to drive multiplexed LED/digit enables or sequential register-file write enables.

Outputs are registered and held between updates. The block sits between control logic and banks of enables.

Parameters:
- IN_W, 5, index width.
- OUT_W, 32, select-word width. Legal range: 2 to 2**IN_W.
- SCAN_DIV, 4, clock cycles per scan step. Must be ≥1; 1 means one step per cycle.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iEna  in  1  block enable.
- iMode  in  2  00 one-hot, 01 thermometer, 10 scan, 11 active-low one-hot.
- iValid  in  1  load strobe for iData in modes 00/01/11.
- iData  in  IN_W  index to decode.
- oData  out  OUT_W  registered select word.
- oIndex  out  IN_W  index currently reflected on oData.
- oValid  out  1  one-cycle pulse: oData updated from a new load or scan step.
- oErr  out  1  registered: last load had iData ≥ OUT_W.

Behaviour:
- Reset (iRst=1 at edge):
  - oData=0, oIndex=0, oValid=0, oErr=0.
  - Scan divider and scan index cleared to 0.
  - Reset has priority over everything, including mid-scan.
- Latency: one cycle. An input sampled at edge N is visible on outputs after edge N.
- iEna=0:
  - Next edge drives oData=0 and oValid=0.
  - oIndex, oErr, divider and scan index hold.
  - When iEna returns to 1 in a load mode, oData stays 0 until the next iValid.
  - In scan mode, stepping resumes from the held divider and index.
- Load modes (00, 01, 11), iEna=1:
  - iValid=1 registers the decode of iData and pulses oValid=1 for one cycle. oIndex=iData.
  - Mode 00: oData bit iData=1, all others 0.
  - Mode 01: oData bits 0..iData=1, higher bits 0. iData=0 gives 0…01; iData=OUT_W-1 gives all ones.
  - Mode 11: bitwise inverse of the mode-00 word.
  - iValid=0: outputs hold, oValid=0.
- Out-of-range load (iData ≥ OUT_W, only possible when OUT_W < 2**IN_W):
  - oErr=1, oValid=1, oIndex=iData.
  - oData forced to all zeros in modes 00 and 01, all ones in mode 11. No select is ever asserted.
  - oErr clears on the next in-range load or on reset; it holds otherwise.
- Scan mode (10), iEna=1:
  - iData and iValid are ignored.
  - The divider counts 0..SCAN_DIV-1. When it wraps, the scan index increments and oValid pulses.
  - The index wraps from OUT_W-1 to 0, never passing through out-of-range values.
  - oData is the one-hot of the scan index; oIndex equals the scan index; oErr=0.
- Entering scan (iMode becomes 10 from another mode at an enabled edge):
  - Divider and index cleared to 0.
  - oData becomes one-hot bit 0, oValid pulses that same edge.
- Leaving scan (iMode changes from 10 to a load mode):
  - Outputs hold their last scan value until the first iValid; oValid=0 meanwhile.
- Mode change between load modes without iValid: outputs hold their old encoding; the new encoding applies on the next load.
- Simultaneous iValid and a mode switch into scan: scan entry wins and the load is discarded.
- At every edge where iEna=1 and the block is not in reset, exactly one of these applies: load, scan step, hold.

Test Plan:
- Reset then mode 00: iRst=1 for 2 cycles, then iValid with iData=5 → after 1 edge oData=0x00000020, oIndex=5, oValid=1 for 1 cycle; then hold with oValid=0.
- Thermometer/active-low (IN_W=5, OUT_W=32): mode 01 with iData=3 → oData=0x0000000F; mode 01 with iData=31 → 0xFFFFFFFF; mode 11 with iData=0 → 0xFFFFFFFE.
- Out-of-range (IN_W=4, OUT_W=10): iData=12 in mode 00 → oData=0, oErr=1, oValid=1; then iData=9 → oData=0x200, oErr=0.
- Scan (SCAN_DIV=3, OUT_W=4): enter mode 10 → oData goes 0001, then 0010 after 3 more cycles, …, 1000, 0001 (wrap). oValid pulses once every 3 cycles.
- Enable/reset mid-scan: drop iEna during the index-2 dwell for 5 cycles → oData=0, no oValid. Restore iEna → scan resumes at index 2 with the remaining divider count. Then assert iRst mid-step → all outputs 0 the next cycle; scan restarts at index 0 after reset releases.
- Priority: iValid=1 with iData=7 on the same edge iMode becomes 10 → oData=one-hot 0 and oIndex=0, and the load is ignored.

Source files
------------

// File: rtl/decoder_scan.sv
// Registered index-to-select decoder: one-hot, thermometer, active-low one-hot,
// and a self-timed scan mode that walks its own index across the select word.
module decoder_scan #(
  parameter int unsigned IN_W     = 5,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEna,
  input  logic [1:0]       iMode,
  input  logic             iValid,
  input  logic [IN_W-1:0]  iData,
  output logic [OUT_W-1:0] oData,
  output logic [IN_W-1:0]  oIndex,
  output logic             oValid,
  output logic             oErr
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] MODE_HOT   = 2'b00;
  localparam logic [1:0] MODE_THERM = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_LOW   = 2'b11;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] scanDiv;
  logic [IN_W-1:0]  scanIdx;

  logic             inRange;
  logic             divWrap;
  logic [IN_W-1:0]  nextScanIdx;
  logic [OUT_W-1:0] loadHot;
  logic [OUT_W-1:0] loadTherm;
  logic [OUT_W-1:0] loadWord;
  logic [OUT_W-1:0] scanHot;
  logic [OUT_W-1:0] nextScanHot;

  // Decode of the load index and of the current/next scan index.
  always_comb begin
    loadHot     = '0;
    loadTherm   = '0;
    scanHot     = '0;
    nextScanHot = '0;
    inRange     = (32'(iData) < OUT_W);
    divWrap     = (scanDiv == DIV_W'(SCAN_DIV - 1));
    nextScanIdx = (scanIdx == IN_W'(OUT_W - 1)) ? '0 : scanIdx + IN_W'(1);
    for (int i = 0; i < int'(OUT_W); i++) begin
      loadHot[i]     = (iData == i[IN_W-1:0]);
      loadTherm[i]   = (i[IN_W-1:0] <= iData);
      scanHot[i]     = (scanIdx == i[IN_W-1:0]);
      nextScanHot[i] = (nextScanIdx == i[IN_W-1:0]);
    end
    // Out-of-range loads never assert a select in any encoding.
    case (iMode)
      MODE_HOT:   loadWord = inRange ? loadHot : '0;
      MODE_THERM: loadWord = inRange ? loadTherm : '0;
      MODE_LOW:   loadWord = inRange ? ~loadHot : '1;
      default:    loadWord = '0;
    endcase
  end

  // Exactly one of load, scan step or hold per enabled edge; reset wins.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= ST_LOAD;
      scanDiv <= '0;
      scanIdx <= '0;
      oData   <= '0;
      oIndex  <= '0;
      oValid  <= 1'b0;
      oErr    <= 1'b0;
    end else if (!iEna) begin
      oData  <= '0;
      oValid <= 1'b0;
    end else if (iMode == MODE_SCAN) begin
      state <= ST_SCAN;
      oErr  <= 1'b0;
      if (state != ST_SCAN) begin
        // Scan entry restarts from index 0 and reports it immediately.
        scanDiv <= '0;
        scanIdx <= '0;
        oData   <= OUT_W'(1);
        oIndex  <= '0;
        oValid  <= 1'b1;
      end else if (divWrap) begin
        scanDiv <= '0;
        scanIdx <= nextScanIdx;
        oData   <= nextScanHot;
        oIndex  <= nextScanIdx;
        oValid  <= 1'b1;
      end else begin
        scanDiv <= scanDiv + DIV_W'(1);
        oData   <= scanHot;
        oIndex  <= scanIdx;
        oValid  <= 1'b0;
      end
    end else begin
      state  <= ST_LOAD;
      oValid <= iValid;
      if (iValid) begin
        oData  <= loadWord;
        oIndex <= iData;
        oErr   <= !inRange;
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan across three parameter sets (32-wide,
// 10-wide with out-of-range indices, and a 4-wide scan with divide-by-3).
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ena;
  logic [1:0] mode;
  logic       valid;
  logic [4:0] dataA;
  logic [3:0] dataB;
  logic [1:0] dataC;

  logic [31:0] oDataA;
  logic [4:0]  oIndexA;
  logic        oValidA, oErrA;
  logic [9:0]  oDataB;
  logic [3:0]  oIndexB;
  logic        oValidB, oErrB;
  logic [3:0]  oDataC;
  logic [1:0]  oIndexC;
  logic        oValidC, oErrC;

  int checks = 0;
  int errors = 0;

  decoder_scan #(.IN_W(5), .OUT_W(32), .SCAN_DIV(4)) uA (
    .iClk(clk), .iRst(rst), .iEna(ena), .iMode(mode), .iValid(valid), .iData(dataA),
    .oData(oDataA), .oIndex(oIndexA), .oValid(oValidA), .oErr(oErrA)
  );

  decoder_scan #(.IN_W(4), .OUT_W(10), .SCAN_DIV(4)) uB (
    .iClk(clk), .iRst(rst), .iEna(ena), .iMode(mode), .iValid(valid), .iData(dataB),
    .oData(oDataB), .oIndex(oIndexB), .oValid(oValidB), .oErr(oErrB)
  );

  decoder_scan #(.IN_W(2), .OUT_W(4), .SCAN_DIV(3)) uC (
    .iClk(clk), .iRst(rst), .iEna(ena), .iMode(mode), .iValid(valid), .iData(dataC),
    .oData(oDataC), .oIndex(oIndexC), .oValid(oValidC), .oErr(oErrC)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    rst = 1'b1; ena = 1'b1; mode = 2'b00; valid = 1'b0;
    dataA = '0; dataB = '0; dataC = '0;

    // Reset held for two edges.
    tick(); tick();
    check("rstDataA", oDataA, 32'h0);
    check("rstIndexA", 32'(oIndexA), 32'h0);
    check("rstValidA", 32'(oValidA), 32'h0);
    check("rstErrA", 32'(oErrA), 32'h0);
    check("rstDataC", 32'(oDataC), 32'h0);

    // One-hot load then hold.
    rst = 1'b0; valid = 1'b1; dataA = 5'd5; dataB = 4'd3;
    tick();
    check("hotDataA", oDataA, 32'h0000_0020);
    check("hotIndexA", 32'(oIndexA), 32'd5);
    check("hotValidA", 32'(oValidA), 32'd1);
    check("hotDataB", 32'(oDataB), 32'h008);
    valid = 1'b0;
    tick();
    check("holdDataA", oDataA, 32'h0000_0020);
    check("holdValidA", 32'(oValidA), 32'd0);

    // Thermometer and active-low.
    mode = 2'b01; valid = 1'b1; dataA = 5'd3;
    tick();
    check("thermDataA3", oDataA, 32'h0000_000F);
    check("thermValidA3", 32'(oValidA), 32'd1);
    dataA = 5'd31;
    tick();
    check("thermDataA31", oDataA, 32'hFFFF_FFFF);
    check("thermIndexA31", 32'(oIndexA), 32'd31);
    mode = 2'b11; dataA = 5'd0;
    tick();
    check("lowDataA0", oDataA, 32'hFFFF_FFFE);

    // Mode change without a load keeps the old encoding.
    mode = 2'b00; valid = 1'b0;
    tick();
    check("modeHoldDataA", oDataA, 32'hFFFF_FFFE);
    check("modeHoldValidA", 32'(oValidA), 32'd0);

    // Out-of-range loads on the 10-wide instance.
    valid = 1'b1; dataB = 4'd12;
    tick();
    check("oorDataB", 32'(oDataB), 32'h000);
    check("oorErrB", 32'(oErrB), 32'd1);
    check("oorValidB", 32'(oValidB), 32'd1);
    check("oorIndexB", 32'(oIndexB), 32'd12);
    mode = 2'b11; dataB = 4'd15;
    tick();
    check("oorLowDataB", 32'(oDataB), 32'h3FF);
    check("oorLowErrB", 32'(oErrB), 32'd1);
    mode = 2'b01; dataB = 4'd10;
    tick();
    check("oorThermDataB", 32'(oDataB), 32'h000);
    check("oorThermErrB", 32'(oErrB), 32'd1);
    mode = 2'b00; dataB = 4'd9;
    tick();
    check("topHotDataB", 32'(oDataB), 32'h200);
    check("topHotErrB", 32'(oErrB), 32'd0);
    mode = 2'b01;
    tick();
    check("topThermDataB", 32'(oDataB), 32'h3FF);
    valid = 1'b0;
    tick();
    check("idleErrB", 32'(oErrB), 32'd0);
    check("idleValidB", 32'(oValidB), 32'd0);

    // Disable in a load mode: data cleared, index held, stays clear after re-enable.
    ena = 1'b0;
    tick();
    check("disDataB", 32'(oDataB), 32'h000);
    check("disIndexB", 32'(oIndexB), 32'd9);
    check("disValidB", 32'(oValidB), 32'd0);
    ena = 1'b1;
    tick();
    check("reenDataB", 32'(oDataB), 32'h000);
    mode = 2'b00; valid = 1'b1; dataB = 4'd4;
    tick();
    check("reenLoadB", 32'(oDataB), 32'h010);

    // Scan on the 4-wide divide-by-3 instance.
    mode = 2'b10; valid = 1'b0;
    tick();
    check("scanEntryDataC", 32'(oDataC), 32'h1);
    check("scanEntryValidC", 32'(oValidC), 32'd1);
    check("scanEntryIndexC", 32'(oIndexC), 32'd0);
    for (int k = 1; k <= 19; k++) begin
      tick();
      idx = (k / 3) % 4;
      check("scanDataC", 32'(oDataC), 32'd1 << idx);
      check("scanValidC", 32'(oValidC), (k % 3 == 0) ? 32'd1 : 32'd0);
      check("scanIndexC", 32'(oIndexC), 32'(idx));
    end

    // Drop enable during the index-2 dwell (divider at 1).
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("scanDisDataC", 32'(oDataC), 32'h0);
      check("scanDisValidC", 32'(oValidC), 32'd0);
      check("scanDisIndexC", 32'(oIndexC), 32'd2);
    end
    ena = 1'b1;
    tick();
    check("resumeDataC", 32'(oDataC), 32'h4);
    check("resumeValidC", 32'(oValidC), 32'd0);
    tick();
    check("resumeStepDataC", 32'(oDataC), 32'h8);
    check("resumeStepValidC", 32'(oValidC), 32'd1);
    check("resumeStepIndexC", 32'(oIndexC), 32'd3);

    // Reset mid-scan, then scan restarts at index 0.
    rst = 1'b1;
    tick();
    check("midRstDataC", 32'(oDataC), 32'h0);
    check("midRstIndexC", 32'(oIndexC), 32'd0);
    check("midRstValidC", 32'(oValidC), 32'd0);
    rst = 1'b0;
    tick();
    check("restartDataC", 32'(oDataC), 32'h1);
    check("restartValidC", 32'(oValidC), 32'd1);
    tick(); tick();
    check("restartDwellC", 32'(oDataC), 32'h1);
    tick();
    check("restartStepC", 32'(oDataC), 32'h2);
    check("restartStepValidC", 32'(oValidC), 32'd1);

    // Leaving scan holds the last scan word.
    mode = 2'b00;
    tick();
    check("leaveDataC", 32'(oDataC), 32'h2);
    check("leaveValidC", 32'(oValidC), 32'd0);
    check("leaveIndexC", 32'(oIndexC), 32'd1);
    valid = 1'b1; dataB = 4'd12;
    tick();
    check("preScanErrB", 32'(oErrB), 32'd1);

    // Load coinciding with scan entry is discarded.
    mode = 2'b10; dataA = 5'd7;
    tick();
    check("prioDataA", oDataA, 32'h0000_0001);
    check("prioIndexA", 32'(oIndexA), 32'd0);
    check("prioValidA", 32'(oValidA), 32'd1);
    check("scanErrB", 32'(oErrB), 32'd0);
    valid = 1'b0;

    // Scan index of the 10-wide instance wraps at 9.
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("wrapIndexB", 32'(oIndexB), 32'((k / 4) % 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
